// File: rtl/bt_status_tx_pkg.sv
// Shared definitions for the Bluetooth status transmitter: frame layout,
// controller state encoding and small helper functions.
package bt_status_tx_pkg;

  // Default frame start byte
  localparam logic [7:0] HEADER_BYTE = 8'hA5;

  // Number of bytes in one status frame (header, song, volume, pause, checksum)
  localparam int FRAME_LEN = 5;

  // Frame controller state encoding
  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_SEND = 3'd2;
  localparam logic [2:0] ST_WAIT = 3'd3;
  localparam logic [2:0] ST_DONE = 3'd4;

  // Clocks per UART bit; shared with the command receiver so both agree
  function automatic int baud_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Frame checksum: XOR of the three payload bytes
  function automatic logic [7:0] frame_checksum(input logic [7:0] b1,
                                                input logic [7:0] b2,
                                                input logic [7:0] b3);
    return b1 ^ b2 ^ b3;
  endfunction

endpackage

// File: rtl/bt_status_tx_uart_tx.sv
// 8N1 UART serialiser. A start request while idle latches the byte and
// shifts out start bit, 8 data bits LSB first and a stop bit, each held
// exactly BAUD_DIV clocks. o_done pulses for one cycle once the stop bit
// has been held for its full period. Requests while busy are ignored.
module bt_status_tx_uart_tx #(
  parameter int BAUD_DIV = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_start,
  input  logic [7:0] i_data,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_done
);

  localparam int CNT_W = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BAUD_DIV - 1);

  logic             busy_q, busy_d;
  logic             tx_q, tx_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic [7:0]       shift_q, shift_d;

  // Next-state logic: bit timing and shifting of the serial frame
  always_comb begin
    busy_d  = busy_q;
    tx_d    = tx_q;
    done_d  = 1'b0;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (!busy_q) begin
      if (i_start) begin
        busy_d  = 1'b1;
        tx_d    = 1'b0;
        shift_d = i_data;
        baud_d  = {CNT_W{1'b0}};
        bit_d   = 4'd0;
      end else begin
        tx_d = 1'b1;
      end
    end else if (baud_q == CNT_MAX) begin
      baud_d = {CNT_W{1'b0}};
      if (bit_q == 4'd9) begin
        busy_d = 1'b0;
        done_d = 1'b1;
        tx_d   = 1'b1;
      end else begin
        bit_d = bit_q + 4'd1;
        if (bit_q == 4'd8) begin
          tx_d = 1'b1;
        end else begin
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
        end
      end
    end else begin
      baud_d = baud_q + CNT_W'(1);
    end
  end

  // State registers; the line idles high out of reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
      baud_q  <= {CNT_W{1'b0}};
      bit_q   <= 4'd0;
      shift_q <= 8'd0;
    end else begin
      busy_q  <= busy_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  assign o_tx   = tx_q;
  assign o_busy = busy_q;
  assign o_done = done_q;

endmodule

// File: rtl/bt_status_tx.sv
// Player status reporter: watches song, volume and pause, and whenever any
// of them differs from the last frame sent (or on an explicit request)
// sends a 5-byte status frame over the UART link to the phone.
module bt_status_tx
  import bt_status_tx_pkg::*;
#(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         BAUD     = 9600,
  parameter logic [7:0] HEADER   = HEADER_BYTE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] i_song_select,
  input  logic [3:0] i_vol_level,
  input  logic       i_pause,
  input  logic       i_req,
  output logic       o_tx,
  output logic       o_busy,
  output logic       o_frame_done
);

  localparam int BAUD_DIV = baud_div(CLK_FREQ, BAUD);
  localparam logic [2:0] LAST_IDX = 3'(FRAME_LEN - 1);

  logic [2:0] state_q, state_d;
  logic       pending_q, pending_d;
  logic [7:0] snap_q, snap_d;      // {song, vol, pause} of the last frame sent
  logic [7:0] cap_q, cap_d;        // payload of the frame in flight
  logic [2:0] idx_q, idx_d;
  logic       busy_q, busy_d;
  logic       frame_done_q, frame_done_d;

  logic [7:0] status_s;
  logic       change_s;
  logic       trigger_s;
  logic [7:0] byte_song_s, byte_vol_s, byte_pause_s;
  logic [7:0] tx_byte_s;
  logic       start_s;
  logic       uart_busy_s;
  logic       uart_done_s;

  assign status_s     = {i_song_select, i_vol_level, i_pause};
  assign change_s     = (status_s != snap_q);
  assign trigger_s    = pending_q | change_s | i_req;
  assign byte_song_s  = {5'b00000, cap_q[7:5]};
  assign byte_vol_s   = {4'b0000, cap_q[4:1]};
  assign byte_pause_s = {7'b0000000, cap_q[0]};
  assign start_s      = (state_q == ST_SEND) && !uart_busy_s;

  // Select the frame byte currently due for transmission
  always_comb begin
    case (idx_q)
      3'd0:    tx_byte_s = HEADER;
      3'd1:    tx_byte_s = byte_song_s;
      3'd2:    tx_byte_s = byte_vol_s;
      3'd3:    tx_byte_s = byte_pause_s;
      3'd4:    tx_byte_s = frame_checksum(byte_song_s, byte_vol_s, byte_pause_s);
      default: tx_byte_s = HEADER;
    endcase
  end

  // Frame sequencing; pending stays sticky so changes during a frame coalesce
  // into exactly one follow-up frame
  always_comb begin
    state_d   = state_q;
    pending_d = trigger_s;
    snap_d    = snap_q;
    cap_d     = cap_q;
    idx_d     = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (trigger_s) begin
          state_d = ST_LOAD;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_LOAD: begin
        cap_d     = status_s;
        snap_d    = status_s;
        pending_d = i_req;
        idx_d     = 3'd0;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (!uart_busy_s) begin
          state_d = ST_WAIT;
        end else begin
          state_d = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (uart_done_s) begin
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 3'd1;
            state_d = ST_SEND;
          end
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    busy_d       = (state_d != ST_IDLE);
    frame_done_d = (state_d == ST_DONE);
  end

  // Controller registers; snapshot resets to match the command receiver
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      snap_q       <= 8'd0;
      cap_q        <= 8'd0;
      idx_q        <= 3'd0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      snap_q       <= snap_d;
      cap_q        <= cap_d;
      idx_q        <= idx_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
    end
  end

  bt_status_tx_uart_tx #(
    .BAUD_DIV(BAUD_DIV)
  ) u_uart_tx (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_start(start_s),
    .i_data (tx_byte_s),
    .o_tx   (o_tx),
    .o_busy (uart_busy_s),
    .o_done (uart_done_s)
  );

  assign o_busy       = busy_q;
  assign o_frame_done = frame_done_q;

endmodule
